// File: rtl/att_pkg.sv
// Shared types and defaults for the ATT serial pattern generator.
// No logic; state encoding, default widths and index-width helper only.
package att_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } att_state_t;

  localparam int PRESCALE_W_DEF = 24;
  localparam int PAT_W_DEF      = 16;

  // Bit-index width for a pattern of pat_w bits; never narrower than one bit.
  function automatic int idx_w(input int pat_w);
    return (pat_w < 2) ? 1 : $clog2(pat_w);
  endfunction

endpackage

// File: rtl/att_prescaler.sv
// Bit-period counter: ticks when the count reaches div, then restarts at zero.
// Tick is combinational from the count register; no backpressure, clr holds it at zero.
module att_prescaler #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] cnt_q;
  logic         at_top;

  // >= rather than == so a count can never run past the period boundary.
  assign at_top = (cnt_q >= div);
  assign tick   = !clr && at_top;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (at_top) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

endmodule

// File: rtl/att_pattern_gen.sv
// Serialises a latched pattern onto ATT, LSB first, each bit held div+1 cycles; optional looping.
// ATT follows the accepting edge by one cycle; pat_ready_o drops for the whole pass and its done cycle.
module att_pattern_gen
  import att_pkg::*;
#(
  parameter int PRESCALE_W = PRESCALE_W_DEF,
  parameter int PAT_W      = PAT_W_DEF
) (
  input  logic                  CLK_MCO,
  input  logic                  RST,
  input  logic [PRESCALE_W-1:0] div_i,
  input  logic [PAT_W-1:0]      pat_i,
  input  logic                  pat_valid_i,
  output logic                  pat_ready_o,
  input  logic                  loop_i,
  output logic                  ATT,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int               IDX_W    = idx_w(PAT_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  att_state_t            state_q;
  att_state_t            state_d;
  logic [PAT_W-1:0]      pat_q;
  logic [PRESCALE_W-1:0] div_q;
  logic [IDX_W-1:0]      idx_q;
  logic [IDX_W-1:0]      idx_d;
  logic                  att_d;
  logic                  busy_d;
  logic                  done_d;
  logic                  ready_d;
  logic                  xfer;
  logic                  tick;
  logic                  last_bit;

  assign xfer     = pat_valid_i && pat_ready_o;
  assign last_bit = (idx_q == LAST_IDX);

  // Counter is held clear outside RUN, so every pass starts on a fresh period.
  att_prescaler #(
    .W (PRESCALE_W)
  ) u_prescaler (
    .clk  (CLK_MCO),
    .rst  (RST),
    .clr  (state_q != RUN),
    .div  (div_q),
    .tick (tick)
  );

  always_ff @(posedge CLK_MCO) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (xfer) state_d = RUN;
      RUN:  if (tick && last_bit && !loop_i) state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d  = idx_q;
    att_d  = ATT;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        att_d = xfer ? pat_i[0] : 1'b0;
      end
      RUN: begin
        if (tick) begin
          if (last_bit) begin
            idx_d  = '0;
            att_d  = loop_i ? pat_q[0] : 1'b0;
            done_d = !loop_i;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            att_d = pat_q[idx_q + IDX_W'(1)];
          end
        end
      end
    endcase
    busy_d  = (state_d == RUN);
    // Ready stays low through the done cycle so a new offer lands one cycle later.
    ready_d = (state_d == IDLE) && !done_d;
  end

  always_ff @(posedge CLK_MCO) begin
    if (RST) begin
      pat_q       <= '0;
      div_q       <= '0;
      idx_q       <= '0;
      ATT         <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      pat_ready_o <= 1'b1;
    end else begin
      if (xfer) begin
        pat_q <= pat_i;
        div_q <= div_i;
      end
      idx_q       <= idx_d;
      ATT         <= att_d;
      busy_o      <= busy_d;
      done_o      <= done_d;
      pat_ready_o <= ready_d;
    end
  end

endmodule

// File: tb/tb_att_pattern_gen.sv
// Directed sequence with randomized patterns, periods and idle-time noise, checked against a bit-period model.
module tb_att_pattern_gen;

  localparam int PW = 16;
  localparam int DW = 24;

  logic          CLK_MCO = 1'b0;
  logic          RST;
  logic [DW-1:0] div_i;
  logic [PW-1:0] pat_i;
  logic          pat_valid_i;
  logic          pat_ready_o;
  logic          loop_i;
  logic          ATT;
  logic          busy_o;
  logic          done_o;

  int passed = 0;
  int total  = 0;

  always #5 CLK_MCO = ~CLK_MCO;

  att_pattern_gen #(
    .PRESCALE_W (DW),
    .PAT_W      (PW)
  ) dut (
    .CLK_MCO     (CLK_MCO),
    .RST         (RST),
    .div_i       (div_i),
    .pat_i       (pat_i),
    .pat_valid_i (pat_valid_i),
    .pat_ready_o (pat_ready_o),
    .loop_i      (loop_i),
    .ATT         (ATT),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  task automatic tick();
    @(posedge CLK_MCO);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Offer a pattern, then expect each bit b for div+1 cycles, repeated for 'passes' passes,
  // followed by a single done cycle. A non-zero 'abort' returns after that many bit-cycles.
  task automatic play(input logic [PW-1:0] pat, input logic [DW-1:0] div, input int passes,
                      input int exp_wait, input int abort);
    int w;
    int k;
    pat_valid_i = 1'b1;
    pat_i       = pat;
    div_i       = div;
    loop_i      = 1'($urandom);
    w = 0;
    do begin
      tick();
      w++;
      chk("done_before_accept", 32'(done_o), 32'd0);
    end while (!busy_o && w < 8);
    chk("accept_latency", w, exp_wait);
    chk("ready_in_run", 32'(pat_ready_o), 32'd0);
    k = 0;
    for (int p = 0; p < passes; p++) begin
      for (int b = 0; b < PW; b++) begin
        for (int c = 0; c <= int'(div); c++) begin
          if (abort > 0 && k == abort) return;
          chk("att_bit", 32'(ATT), 32'(pat[b]));
          chk("busy_run", 32'(busy_o), 32'd1);
          chk("done_run", 32'(done_o), 32'd0);
          if (c == 0) chk("ready_run", 32'(pat_ready_o), 32'd0);
          k++;
          // Offers and period changes during RUN must have no effect.
          pat_valid_i = 1'($urandom);
          pat_i       = PW'($urandom);
          div_i       = DW'($urandom);
          if (c == int'(div) && b == PW - 1) loop_i = (p != passes - 1);
          else loop_i = 1'($urandom);
          tick();
        end
      end
    end
    pat_valid_i = 1'b0;
    chk("done_pulse", 32'(done_o), 32'd1);
    chk("att_after_pass", 32'(ATT), 32'd0);
    chk("busy_after_pass", 32'(busy_o), 32'd0);
    chk("ready_in_done", 32'(pat_ready_o), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST         = 1'b1;
    div_i       = '0;
    pat_i       = '0;
    pat_valid_i = 1'b0;
    loop_i      = 1'b0;
    tick();
    tick();
    chk("reset_att", 32'(ATT), 32'd0);
    chk("reset_busy", 32'(busy_o), 32'd0);
    chk("reset_done", 32'(done_o), 32'd0);
    chk("reset_ready", 32'(pat_ready_o), 32'd1);
    RST = 1'b0;
    tick();
    chk("idle_ready", 32'(pat_ready_o), 32'd1);

    // Toggle every cycle over four looped passes.
    play(16'h5555, 24'd0, 4, 1, 0);
    // Back-to-back offer lands two cycles after the done edge.
    play(16'h00F1, 24'd3, 1, 2, 0);
    // Loop once then stop mid-way through loop noise.
    play(16'hA3C5, 24'd1, 2, 2, 0);

    for (int i = 0; i < 6; i++) begin
      play(PW'($urandom), DW'($urandom_range(0, 3)), int'($urandom_range(1, 3)), 2, 0);
    end

    // Abort mid-pass with reset; an offer during reset must not be taken.
    play(16'hFFFF, 24'd2, 1, 2, 10);
    RST         = 1'b1;
    pat_valid_i = 1'b1;
    pat_i       = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_att", 32'(ATT), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
    end
    RST         = 1'b0;
    pat_valid_i = 1'b0;
    tick();
    chk("post_rst_ready", 32'(pat_ready_o), 32'd1);
    chk("post_rst_done", 32'(done_o), 32'd0);
    chk("post_rst_busy", 32'(busy_o), 32'd0);

    play(16'h1234, 24'd0, 1, 1, 0);
    tick();
    chk("final_done_clear", 32'(done_o), 32'd0);
    chk("final_ready", 32'(pat_ready_o), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/att_pattern_gen.md
ATT_PATTERN_GEN -- requirements
Module: att_pattern_gen

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 24, width of bit-period divider.
REQ-002 SHALL have parameter PAT_W, default 16, pattern length in bits (min 2).
REQ-003 SHALL have port CLK_MCO  in  1  sole clock, from global buffer.
REQ-004 SHALL have port RST  in  1  reset; one clock, reset is synchronous and active-high.
REQ-005 SHALL have port div_i  in  PRESCALE_W  bit period minus 1, in CLK_MCO cycles.
REQ-006 SHALL have port pat_i  in  PAT_W  pattern; bit 0 emitted first.
REQ-007 SHALL have port pat_valid_i  in  1  pattern offer.
REQ-008 SHALL have port pat_ready_o  out  1  pattern accepted when high with pat_valid_i.
REQ-009 SHALL have port loop_i  in  1  repeat pattern at end of pass.
REQ-010 SHALL have port ATT  out  1  registered serial output, drives ATT output pad.
REQ-011 SHALL have port busy_o  out  1  high while in RUN.
REQ-012 SHALL have port done_o  out  1  one-cycle pulse on pass end with no repeat.

Function
REQ-013 SHALL implement states IDLE and RUN only.
REQ-014 IDLE: pat_ready_o=1, ATT=0, busy_o=0.
REQ-015 Handshake: transfer when pat_valid_i && pat_ready_o at a rising edge; pat_i and div_i latched that edge; no other sampling of either.
REQ-016 On transfer: state->RUN, bit index=0, prescale count=0; ATT=pat_i[0] from the next cycle.
REQ-017 RUN: pat_ready_o=0, busy_o=1; pat_valid_i ignored.
REQ-018 Prescale count increments each cycle; at count==latched div a tick occurs and count returns to 0; each bit held exactly div+1 cycles.
REQ-019 div=0: tick every cycle; pattern 16'h5555 with loop_i=1 SHALL toggle ATT every cycle.
REQ-020 Tick with index<PAT_W-1: index+1, ATT=next bit on following cycle.
REQ-021 Tick with index==PAT_W-1 and loop_i=1 (sampled that cycle): index=0, ATT=latched bit 0, stay RUN, no done_o.
REQ-022 Tick with index==PAT_W-1 and loop_i=0: state->IDLE, ATT=0, done_o=1 for one cycle, pat_ready_o=1 next cycle.
REQ-023 New pattern SHALL NOT be accepted in the done_o cycle; earliest acceptance is cycle after done_o.
REQ-024 Index arithmetic SHALL not wrap past PAT_W-1; count SHALL not exceed latched div.
REQ-025 All outputs registered; no combinational path from inputs to ATT.

Reset
REQ-026 RST high at a rising edge: state=IDLE, ATT=0, busy_o=0, done_o=0, count=0, index=0, pattern reg=0.
REQ-027 RST mid-RUN SHALL abort the pass without done_o; pat_ready_o=1 cycle after RST deasserts.
REQ-028 RST SHALL dominate simultaneous handshake or tick.

Structure
REQ-029 Package att_pkg SHALL hold state enum (IDLE, RUN), default PRESCALE_W/PAT_W constants.
REQ-030 Sub-module att_prescaler SHALL implement the loadable counter (clear, div input, tick output); FSM/shift logic in top of block.

Verification
REQ-031 Reset: RST high 3 cycles mid-RUN -> ATT=0, busy_o=0, done_o never pulsed, pat_ready_o=1 after release.
REQ-032 div=0, pat=16'h5555, loop=1 -> ATT 1,0,1,0... each cycle for 64 cycles, done_o never.
REQ-033 div=3, pat=16'h00F1, loop=0 -> ATT=1 four cycles, 0 for 12, 1 for 16, 0 for 32; done_o on cycle 64 after load; busy_o low next.
REQ-034 Handshake: pat_valid_i held high in RUN with new pat -> ignored; accepted first cycle pat_ready_o=1 after done_o.
REQ-035 loop_i 1->0 mid-pass, div=1, PAT_W=16 -> current pass completes (32 cycles), then IDLE with single done_o.
REQ-036 div_i changed during RUN from 3 to 0 -> bit period remains 4 cycles until next load.
